gb_timer: RTL and testbench

//   Game Boy DIV/TIMA/TMA/TAC timer unit. Consumes the one-cycle `enable` strobe from
//   the clock divider as its base tick (CPU M-clock rate). Exposes the four timer

---
 rtl/gb_timer_pkg.sv | 21 ++
 rtl/gb_falling_edge.sv | 22 ++
 rtl/gb_timer.sv | 130 +++++++++++++
 tb/tb_gb_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the Game Boy timer unit.
//   - Register offsets from BASE_ADDR (DIV, TIMA, TMA, TAC).
//   - TAC[1:0] clock-select encodings. Each encoding names the sys_cnt bit it taps.
//   - Read-back value of the unimplemented TAC bits.
package gb_timer_pkg;

    localparam logic [1:0] OFF_DIV  = 2'd0;
    localparam logic [1:0] OFF_TIMA = 2'd1;
    localparam logic [1:0] OFF_TMA  = 2'd2;
    localparam logic [1:0] OFF_TAC  = 2'd3;

    typedef enum logic [1:0] {
        TAC_SEL_BIT9 = 2'b00,
        TAC_SEL_BIT3 = 2'b01,
        TAC_SEL_BIT5 = 2'b10,
        TAC_SEL_BIT7 = 2'b11
    } tac_sel_e;

    localparam logic [4:0] TAC_UNUSED_READ = 5'b11111;

endpackage

// File: rtl/gb_falling_edge.sv
// 1-bit falling-edge detector.
//   clock  : system clock
//   reset  : asynchronous, active-low reset (history cleared to 0)
//   d_i    : sampled level
//   fall_o : high in the cycle where d_i is 0 and it was 1 on the previous clock
module gb_falling_edge (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic fall_o
);

    logic d_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) d_q <= 1'b0;
        else        d_q <= d_i;
    end

    assign fall_o = d_q & ~d_i;

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer.
//   clock    : system clock
//   reset    : asynchronous, active-low reset
//   tick     : base-rate strobe; sys_cnt advances only on clocks where it is high
//   addr     : CPU bus address; DIV at BASE_ADDR, TIMA/TMA/TAC at +1/+2/+3
//   wr_en    : one-cycle write strobe
//   data_in  : write data
//   data_out : registered read data (8'hFF when addr misses)
//   selected : registered address hit
//   irq      : one-cycle pulse after a TIMA overflow
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        irq
);
    import gb_timer_pkg::*;

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic [7:0]  rd_q, rd_d;
    logic        sel_q;
    logic        irq_q, irq_d;

    // Unsigned wrap-around subtract keeps the range check correct for any BASE_ADDR.
    logic [15:0] rel;
    logic        hit;
    logic [1:0]  off;
    assign rel = addr - BASE_ADDR;
    assign hit = (rel < 16'd4);
    assign off = rel[1:0];

    logic wr_div, wr_tima, wr_tma, wr_tac;
    assign wr_div  = wr_en & hit & (off == OFF_DIV);
    assign wr_tima = wr_en & hit & (off == OFF_TIMA);
    assign wr_tma  = wr_en & hit & (off == OFF_TMA);
    assign wr_tac  = wr_en & hit & (off == OFF_TAC);

    // Gate is evaluated every clock, so disabling the timer, changing the select
    // or clearing DIV while the tap is high looks like a falling edge and bumps TIMA.
    logic tap, gate, inc;

    always_comb begin
        tap = 1'b0;
        case (tac_sel_e'(tac_q[1:0]))
            TAC_SEL_BIT9: tap = cnt_q[9];
            TAC_SEL_BIT3: tap = cnt_q[3];
            TAC_SEL_BIT5: tap = cnt_q[5];
            TAC_SEL_BIT7: tap = cnt_q[7];
            default:      tap = 1'b0;
        endcase
    end

    assign gate = tac_q[2] & tap;

    gb_falling_edge u_gate_edge (
        .clock  (clock),
        .reset  (reset),
        .d_i    (gate),
        .fall_o (inc)
    );

    always_comb begin
        cnt_d = cnt_q + {15'd0, tick};
        if (wr_div) cnt_d = 16'h0000;

        tma_d = wr_tma ? data_in : tma_q;
        tac_d = wr_tac ? data_in[2:0] : tac_q;

        // A TIMA write beats any increment. On overflow TIMA reloads from tma_d so
        // a same-cycle TMA write is picked up immediately.
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (wr_tima) begin
            tima_d = data_in;
        end else if (inc) begin
            if (tima_q == 8'hFF) begin
                tima_d = tma_d;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end

        // Read mux samples pre-write state.
        rd_d = 8'hFF;
        if (hit) begin
            case (off)
                OFF_DIV:  rd_d = cnt_q[15:8];
                OFF_TIMA: rd_d = tima_q;
                OFF_TMA:  rd_d = tma_q;
                default:  rd_d = {TAC_UNUSED_READ, tac_q};
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 16'h0000;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            rd_q   <= 8'hFF;
            sel_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            rd_q   <= rd_d;
            sel_q  <= hit;
            irq_q  <= irq_d;
        end
    end

    assign data_out = rd_q;
    assign selected = sel_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer. Each driven cycle pushes the expected registered
// outputs computed by a behavioural model; a monitor pops and compares after the
// following rising edge.
module tb_gb_timer;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        wr_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        selected;
    logic        irq;

    gb_timer #(.BASE_ADDR(16'hFF04)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .addr     (addr),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .data_out (data_out),
        .selected (selected),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       i;
        string      name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference state: plain integers, counter bit positions looked up by TAC select.
    int m_cnt, m_tima, m_tma, m_tac, m_hist, m_dout, m_sel, m_irq;
    int TAP[4] = '{9, 3, 5, 7};

    task automatic model_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_hist = 0;
        m_dout = 255; m_sel = 0; m_irq = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic step_push(input int want, input string nm);
        int gate, fall, off, hit, wr;
        exp_t e;
        gate = (((m_tac >> 2) & 1) == 1 && ((m_cnt >> TAP[m_tac & 3]) & 1) == 1) ? 1 : 0;
        fall = (m_hist == 1 && gate == 0) ? 1 : 0;
        off  = int'(addr) - 32'hFF04;
        hit  = (off >= 0 && off < 4) ? 1 : 0;
        if (hit == 0)      m_dout = 255;
        else if (off == 0) m_dout = (m_cnt / 256) % 256;
        else if (off == 1) m_dout = m_tima;
        else if (off == 2) m_dout = m_tma;
        else               m_dout = 248 + m_tac;
        m_sel = hit;
        wr = (wr_en && hit == 1) ? off : -1;
        m_irq = (fall == 1 && m_tima == 255 && wr != 1) ? 1 : 0;
        if (wr == 1)        m_tima = int'(data_in);
        else if (fall == 1) m_tima = (m_tima == 255) ? ((wr == 2) ? int'(data_in) : m_tma) : m_tima + 1;
        if (wr == 2) m_tma = int'(data_in);
        if (wr == 3) m_tac = int'(data_in) % 8;
        m_cnt  = (wr == 0) ? 0 : (m_cnt + int'(tick)) % 65536;
        m_hist = gate;
        e.d = (want >= 0) ? 8'(want) : 8'(m_dout);
        e.s = (m_sel == 1);
        e.i = (m_irq == 1);
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic cyc(input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic t, input int want = -1, input string nm = "cyc");
        @(negedge clock);
        wr_en = w; addr = a; data_in = d; tick = t;
        step_push(want, nm);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Leave the selected tap high (cnt=8, TAC=bit3), TIMA=FF, then clear DIV so
    // the following cycle sees a falling gate and overflows.
    task automatic arm_overflow();
        cyc(1'b1, A_DIV, 8'h00, 1'b0);
        repeat (8) cyc(1'b0, 16'h0000, 8'h00, 1'b1);
        cyc(1'b1, A_TIMA, 8'hFF, 1'b0);
        cyc(1'b1, A_DIV, 8'h00, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        wr_en = 1'b0; addr = 16'h0000; data_in = 8'h00; tick = 1'b0;
        reset = 1'b1;
        model_reset();
        step_push(-1, "post_reset");
    endtask

    // Monitor: compare one expected entry per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (data_out !== e.d || selected !== e.s || irq !== e.i) begin
                    failures++;
                    $display("FAIL %s: dout=%h sel=%b irq=%b expected dout=%h sel=%b irq=%b",
                             e.name, data_out, selected, irq, e.d, e.s, e.i);
                end
            end
        end
    end

    initial begin
        int r, mode;
        logic [15:0] a;
        model_reset();

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_dout", int'(data_out), 8'hFF);
        chk("rst_sel", int'(selected), 0);
        chk("rst_irq", int'(irq), 0);
        release_reset();

        // 256 ticks -> DIV=1, TIMA untouched
        repeat (256) cyc(1'b0, 16'h0000, 8'h00, 1'b1);
        cyc(1'b0, A_DIV, 8'h00, 1'b0, 8'h01, "t1_div");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h00, "t1_tima");

        // bit3 tap, FE -> FF -> reload 42 with irq
        cyc(1'b1, A_TAC, 8'h05, 1'b0);
        cyc(1'b1, A_TIMA, 8'hFE, 1'b0);
        cyc(1'b1, A_TMA, 8'h42, 1'b0);
        cyc(1'b1, A_DIV, 8'h00, 1'b0);
        repeat (34) cyc(1'b0, A_TIMA, 8'h00, 1'b1, -1, "t2_run");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h42, "t2_reload");

        // DIV write while tap high -> one extra increment
        cyc(1'b1, A_DIV, 8'h00, 1'b0);
        repeat (8) cyc(1'b0, A_DIV, 8'h00, 1'b1, -1, "t3_run");
        cyc(1'b1, A_DIV, 8'h00, 1'b0);
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, -1, "t3_edge");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h43, "t3_tima");
        cyc(1'b0, A_DIV, 8'h00, 1'b0, 8'h00, "t3_div");

        // TIMA write on overflow cycle wins, no irq
        arm_overflow();
        cyc(1'b1, A_TIMA, 8'h10, 1'b0, -1, "t4a_ovf");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h10, "t4a_tima");
        // TMA write on overflow cycle: new value loads, irq fires
        arm_overflow();
        cyc(1'b1, A_TMA, 8'h77, 1'b0, -1, "t4b_ovf");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h77, "t4b_tima");

        // TAC read-back and out-of-range read
        cyc(1'b1, A_TAC, 8'hFF, 1'b0);
        cyc(1'b0, A_TAC, 8'h00, 1'b0, 8'hFF, "t5_tac_ff");
        cyc(1'b1, A_TAC, 8'h00, 1'b0);
        cyc(1'b0, A_TAC, 8'h00, 1'b0, 8'hF8, "t5_tac_00");
        cyc(1'b0, 16'hFF08, 8'h00, 1'b0, 8'hFF, "t5_oor");
        cyc(1'b0, 16'hFF03, 8'h00, 1'b0, 8'hFF, "t5_below");

        // Reset while irq is high
        cyc(1'b1, A_TAC, 8'h05, 1'b0);
        arm_overflow();
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, -1, "t6_ovf");
        @(negedge clock);
        wr_en = 1'b0; tick = 1'b0; addr = 16'h0000;
        chk("t6_irq_before", int'(irq), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_irq", int'(irq), 0);
        chk("t6_rst_dout", int'(data_out), 8'hFF);
        chk("t6_rst_sel", int'(selected), 0);
        model_reset();
        repeat (2) @(negedge clock);
        release_reset();
        cyc(1'b0, A_DIV, 8'h00, 1'b0, 8'h00, "t6_div");
        cyc(1'b0, A_TIMA, 8'h00, 1'b0, 8'h00, "t6_tima");
        cyc(1'b0, A_TAC, 8'h00, 1'b0, 8'hF8, "t6_tac");
        repeat (4) cyc(1'b0, A_TIMA, 8'h00, 1'b1, -1, "t6_idle");

        // Randomized traffic, tick alternating between continuous and sparse
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mode = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            a = (r < 5) ? 16'($urandom) : 16'hFF02 + 16'($urandom_range(0, 7));
            if (a == A_DIV && $urandom_range(0, 3) != 0) r = 99;
            cyc((r < 15), a, 8'($urandom), (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                -1, "rand");
        end

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
